// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Holds the sequencer state enum, the frame counter width and the FFT size
// helper (N = 2^LOG2N) used by the top and by the burst counter.
package fft_seq_pkg;

  localparam int unsigned FRAME_IDX_W = 16;
  localparam int unsigned LOG2N_DEF   = 6;
  localparam int unsigned N_DEF       = 1 << LOG2N_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FILT_WAIT,
    LOAD,
    FFT_RUN,
    READ,
    NEXT,
    FINISH
  } seq_state_t;

  // FFT size for a given log2 size
  function automatic int unsigned fft_n(input int unsigned log2n);
    return 1 << log2n;
  endfunction

endpackage

// File: rtl/seq_burst_ctr.sv
// N-address burst counter.
// A go pulse loads addr with base; addr then advances once per cycle for N
// cycles (wrapping modulo 2^AW). valid follows each issued address one cycle
// later, matching a 1-cycle-latency RAM, and last marks the Nth valid.
// Ports: clk, rst (sync, active-high), go, base -> addr, valid, last.
module seq_burst_ctr
  import fft_seq_pkg::*;
#(
  parameter int unsigned LOG2N = 6,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic          last
);

  localparam int unsigned N = fft_n(LOG2N);

  logic             active;
  logic [LOG2N-1:0] k;
  logic             at_end;

  assign at_end = (k == LOG2N'(N - 1));

  // Address issue plus the one-cycle-delayed qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      k      <= '0;
      addr   <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
    end else begin
      valid <= active;
      last  <= active && at_end;
      if (go) begin
        active <= 1'b1;
        k      <= '0;
        addr   <= base;
      end else if (active) begin
        k    <= k + LOG2N'(1);
        addr <= addr + AW'(1);
        if (at_end) begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT frame sequencer: waits for the filter buffer, then for each of
// NUM_FRAMES frames copies N source samples (starting at base, advancing by
// HOP per frame) into the window RAM, kicks the FFT, and streams the N
// magnitudes out with mag_valid/mag_last.
// Ports: clk, rst (sync, active-high), start, filt_done; source RAM
// (src_addr/src_data), window RAM (win_we/win_addr/win_data), FFT handshake
// (fft_start/fft_done), magnitude RAM (mag_addr/mag_data), magnitude stream
// (mag_valid/mag_out/mag_last), status (frame_idx, busy, done, err).
// Build option: SEQ_WATCHDOG_EN adds an FFT_RUN watchdog that raises err and
// finishes the run after TIMEOUT_CYC cycles without fft_done.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LOG2N       = 6,
  parameter int unsigned HOP         = 32,
  parameter int unsigned SRC_AW      = 10,
  parameter int unsigned NUM_FRAMES  = 28,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   filt_done,
  output logic [SRC_AW-1:0]      src_addr,
  input  logic [DATA_W-1:0]      src_data,
  output logic                   win_we,
  output logic [LOG2N-1:0]       win_addr,
  output logic [DATA_W-1:0]      win_data,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic [LOG2N-1:0]       mag_addr,
  input  logic [DATA_W-1:0]      mag_data,
  output logic                   mag_valid,
  output logic [DATA_W-1:0]      mag_out,
  output logic                   mag_last,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  seq_state_t        state;
  logic [SRC_AW-1:0] base;
  logic [SRC_AW-1:0] ld_base;
  logic              ld_go;
  logic              ld_last;
  logic              rd_go;
  logic              last_frame;
  logic              wd_expire;

  assign last_frame = (frame_idx == FRAME_IDX_W'(NUM_FRAMES - 1));

  // Launch a load burst on leaving FILT_WAIT, or from NEXT with the advanced base
  assign ld_go   = ((state == FILT_WAIT) && filt_done) || ((state == NEXT) && !last_frame);
  assign ld_base = (state == NEXT) ? (base + SRC_AW'(HOP)) : base;

  // fft_done seen while our own kick is still high belongs to a stale FFT
  assign rd_go = (state == FFT_RUN) && fft_done && !fft_start;

  seq_burst_ctr #(.LOG2N(LOG2N), .AW(SRC_AW)) u_load_ctr (
    .clk   (clk),
    .rst   (rst),
    .go    (ld_go),
    .base  (ld_base),
    .addr  (src_addr),
    .valid (win_we),
    .last  (ld_last)
  );

  seq_burst_ctr #(.LOG2N(LOG2N), .AW(LOG2N)) u_read_ctr (
    .clk   (clk),
    .rst   (rst),
    .go    (rd_go),
    .base  ('0),
    .addr  (mag_addr),
    .valid (mag_valid),
    .last  (mag_last)
  );

  // RAM read data passes straight through, gated so idle outputs stay zero
  assign win_data = win_we    ? src_data : '0;
  assign mag_out  = mag_valid ? mag_data : '0;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == FFT_RUN) && !rd_go && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Cycles spent in FFT_RUN; cleared in every other state
  always_ff @(posedge clk) begin
    if (rst || (state != FFT_RUN)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Sticky timeout flag, cleared by the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if (wd_expire) begin
      err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // Sequencer FSM and its registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      frame_idx <= '0;
      fft_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_addr  <= '0;
    end else begin
      fft_start <= 1'b0;
      // base is constant across a burst, so this recovers the delayed index k
      win_addr  <= LOG2N'(src_addr - base);
      case (state)
        IDLE: begin
          if (start) begin
            done      <= 1'b0;
            frame_idx <= '0;
            base      <= '0;
            busy      <= 1'b1;
            state     <= FILT_WAIT;
          end
        end
        FILT_WAIT: begin
          if (filt_done) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (ld_last) begin
            fft_start <= 1'b1;
            state     <= FFT_RUN;
          end
        end
        FFT_RUN: begin
          if (rd_go) begin
            state <= READ;
          end else if (wd_expire) begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        READ: begin
          if (mag_last) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (last_frame) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            frame_idx <= frame_idx + FRAME_IDX_W'(1);
            base      <= ld_base;
            state     <= LOAD;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, sample and magnitude width.
REQ-002 The module SHALL have parameter LOG2N, default 6, FFT size N = 2^LOG2N.
REQ-003 The module SHALL have parameter HOP, default 32, source-address advance per frame (1..N).
REQ-004 The module SHALL have parameter SRC_AW, default 10, source buffer address width.
REQ-005 The module SHALL have parameter NUM_FRAMES, default 28, frames per run (>=1).
REQ-006 The module SHALL have parameter TIMEOUT_CYC, default 1000000, FFT watchdog limit.
REQ-007 The module SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- start  in  1  run request pulse
- filt_done  in  1  filter output buffer complete
- src_addr  out  SRC_AW  source buffer read address
- src_data  in  DATA_W  source read data, 1-cycle latency
- win_we  out  1  window RAM write enable
- win_addr  out  LOG2N  window RAM address
- win_data  out  DATA_W  window RAM write data
- fft_start  out  1  one-cycle FFT kick
- fft_done  in  1  FFT complete pulse
- mag_addr  out  LOG2N  magnitude RAM read address
- mag_data  in  DATA_W  magnitude read data, 1-cycle latency
- mag_valid  out  1  mag_out qualifier
- mag_out  out  DATA_W  magnitude sample
- mag_last  out  1  with last mag_valid of a frame
- frame_idx  out  16  current frame number
- busy  out  1  high in every state except IDLE
- done  out  1  run finished
- err  out  1  watchdog expired

Function
REQ-008 The FSM SHALL have states IDLE, FILT_WAIT, LOAD, FFT_RUN, READ, NEXT, FINISH.
REQ-009 In IDLE, start=1 SHALL clear done/err/frame_idx, set base=0, and enter FILT_WAIT next cycle; start in any other state SHALL be ignored.
REQ-010 FILT_WAIT SHALL advance to LOAD on the cycle after filt_done=1 is sampled; filt_done outside FILT_WAIT SHALL be ignored.
REQ-011 LOAD SHALL drive src_addr=base+k for k=0..N-1 on consecutive cycles, then assert win_we with win_addr=k and win_data=src_data one cycle later; LOAD SHALL last N+1 cycles.
REQ-012 src_addr SHALL wrap modulo 2^SRC_AW.
REQ-013 On LOAD exit, fft_start SHALL pulse for exactly one cycle on entry to FFT_RUN.
REQ-014 FFT_RUN SHALL advance to READ on the cycle after fft_done=1; fft_done coincident with fft_start SHALL be ignored.
REQ-015 READ SHALL drive mag_addr=0..N-1 on consecutive cycles and produce N mag_valid pulses one cycle behind, with mag_last on the Nth, over N+1 cycles.
REQ-016 NEXT SHALL, if frame_idx==NUM_FRAMES-1, enter FINISH; otherwise it SHALL increment frame_idx, add HOP to base, and re-enter LOAD without a new filt_done wait.
REQ-017 FINISH SHALL assert done for one cycle, then return to IDLE; done SHALL hold low until FINISH.
REQ-018 win_we, fft_start, mag_valid, and mag_last SHALL be low in every state except those named above.

Reset
REQ-019 rst SHALL, on the next clk edge from any state including mid-LOAD/READ, force IDLE and zero all outputs, base, and counters.
REQ-020 No write or valid pulse SHALL issue on the cycle following rst.

Configuration
REQ-021 With SEQ_WATCHDOG_EN defined, FFT_RUN SHALL count cycles, and on reaching TIMEOUT_CYC without fft_done it SHALL set err=1 (sticky until next start) and enter FINISH.
REQ-022 Without SEQ_WATCHDOG_EN, FFT_RUN SHALL wait indefinitely, err SHALL tie to 0, and the counter SHALL not exist.

Structure
REQ-023 The shared package fft_seq_pkg SHALL hold the state enum and the constants N and the frame_idx width.
REQ-024 A sub-module seq_burst_ctr SHALL implement the N-address counter with 1-cycle delayed valid/last, and SHALL be instantiated for both LOAD and READ.

Verification
REQ-025 N=64, HOP=32, NUM_FRAMES=2, src_data=addr: frame0 win_data 0..63, frame1 win_data 32..95, 128 mag_valid, 2 mag_last, done once.
REQ-026 base=1000 and SRC_AW=10: src_addr sequence 1000..1023 then 0..39.
REQ-027 rst asserted at the 10th LOAD cycle: next cycle busy=0 and win_we=0; a fresh start restarts at frame_idx=0.
REQ-028 start pulsed in FFT_RUN and filt_done pulsed in READ: no state change and no duplicated frame.
REQ-029 SEQ_WATCHDOG_EN, TIMEOUT_CYC=100, fft_done never asserted: err=1 and done=1 exactly 100 cycles after fft_start, then IDLE.
REQ-030 fft_done held high on the fft_start cycle, then pulsed 5 cycles later: READ entered on the cycle after the later pulse.
